// File: rtl/pwl_act_pkg.sv
// Shared types and fixed-point constants for the piecewise-linear activation unit.
// The constants are functions of the fractional bit count so every module that
// imports this package agrees on the Q format.
package pwl_act_pkg;

    // Widest lane word the stage struct can carry; lanes narrower than this
    // are zero-extended into the value field.
    localparam int unsigned PWL_MAX_W = 64;

    typedef enum logic [1:0] {
        PWL_SIGMOID = 2'b00,
        PWL_TANH    = 2'b01,
        PWL_RELU    = 2'b10,
        PWL_BYPASS  = 2'b11
    } pwl_mode_e;

    // Per-lane pipeline payload: a non-negative magnitude plus the sign it came from.
    typedef struct packed {
        logic [PWL_MAX_W-1:0] value;
        logic                 sign;
    } pwl_lane_t;

    function automatic logic [PWL_MAX_W-1:0] pwl_one(input int unsigned frac);
        return PWL_MAX_W'(1) << frac;
    endfunction

    function automatic logic [PWL_MAX_W-1:0] pwl_half(input int unsigned frac);
        return PWL_MAX_W'(1) << (frac - 1);
    endfunction

    // 0.625 = 5/8
    function automatic logic [PWL_MAX_W-1:0] pwl_c0625(input int unsigned frac);
        return PWL_MAX_W'(5) << (frac - 3);
    endfunction

    // 0.84375 = 27/32
    function automatic logic [PWL_MAX_W-1:0] pwl_c084375(input int unsigned frac);
        return PWL_MAX_W'(27) << (frac - 5);
    endfunction

    function automatic logic [PWL_MAX_W-1:0] pwl_c1(input int unsigned frac);
        return PWL_MAX_W'(1) << frac;
    endfunction

    // 2.375 = 19/8
    function automatic logic [PWL_MAX_W-1:0] pwl_c2375(input int unsigned frac);
        return PWL_MAX_W'(19) << (frac - 3);
    endfunction

    function automatic logic [PWL_MAX_W-1:0] pwl_c5(input int unsigned frac);
        return PWL_MAX_W'(5) << frac;
    endfunction

endpackage

// File: rtl/pwl_sigmoid_seg.sv
// Positive-half sigmoid approximation for one lane: picks the segment from the
// magnitude and forms offset + scaled magnitude. Purely combinational.
module pwl_sigmoid_seg
    import pwl_act_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int pFRAC_NUM   = 16
) (
    input  logic [pDATA_WIDTH-1:0] a_i,
    output logic [pDATA_WIDTH-1:0] p_o
);

    localparam logic [pDATA_WIDTH-1:0] cOne     = pDATA_WIDTH'(pwl_one(pFRAC_NUM));
    localparam logic [pDATA_WIDTH-1:0] cHalf    = pDATA_WIDTH'(pwl_half(pFRAC_NUM));
    localparam logic [pDATA_WIDTH-1:0] c0625    = pDATA_WIDTH'(pwl_c0625(pFRAC_NUM));
    localparam logic [pDATA_WIDTH-1:0] c084375  = pDATA_WIDTH'(pwl_c084375(pFRAC_NUM));
    localparam logic [pDATA_WIDTH-1:0] c1       = pDATA_WIDTH'(pwl_c1(pFRAC_NUM));
    localparam logic [pDATA_WIDTH-1:0] c2375    = pDATA_WIDTH'(pwl_c2375(pFRAC_NUM));
    localparam logic [pDATA_WIDTH-1:0] c5       = pDATA_WIDTH'(pwl_c5(pFRAC_NUM));

    // Segment select on the unsigned magnitude, then offset plus logical shift.
    always_comb begin
        if (a_i >= c5) begin
            p_o = cOne;
        end else if (a_i >= c2375) begin
            p_o = c084375 + (a_i >> 5);
        end else if (a_i >= c1) begin
            p_o = c0625 + (a_i >> 3);
        end else begin
            p_o = cHalf + (a_i >> 2);
        end
    end

endmodule

// File: rtl/pwl_activation.sv
// Multi-lane piecewise-linear activation unit (sigmoid / tanh / ReLU / bypass)
// with a 3-stage valid/ready pipeline that stalls as a whole under backpressure.
// Build option: define PWL_ACT_TANH_EN to include the tanh doubler and post-scale;
// without it, mode 01 behaves as bypass.
module pwl_activation
    import pwl_act_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int pFRAC_NUM   = 16,
    parameter int pLANES      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_mode,
    input  logic [pLANES*pDATA_WIDTH-1:0] data_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [pLANES*pDATA_WIDTH-1:0] data_out
);

    localparam int W = pDATA_WIDTH;
    localparam logic [W-1:0] cOne   = W'(pwl_one(pFRAC_NUM));
    localparam logic [W-1:0] maxPos = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] minNeg = {1'b1, {(W-1){1'b0}}};

    if (pFRAC_NUM < 5 || (pDATA_WIDTH - pFRAC_NUM) < 4 || pDATA_WIDTH > int'(PWL_MAX_W)) begin : g_bad_params
        $error("pwl_activation: need pFRAC_NUM >= 5, at least 4 integer bits, and width <= PWL_MAX_W");
    end

    pwl_mode_e                     inMode;
    logic                          advance;

    logic [W-1:0]                  laneIn    [pLANES];
    logic [W-1:0]                  s1Operand [pLANES];
    pwl_lane_t                     s1Lane_d  [pLANES];
    pwl_lane_t                     s1Lane_q  [pLANES];
    logic [W-1:0]                  s1Raw_q   [pLANES];
    pwl_mode_e                     s1Mode_q;
    logic                          s1Valid_q;

    logic [W-1:0]                  segP      [pLANES];
    pwl_lane_t                     s2Lane_d  [pLANES];
    pwl_lane_t                     s2Lane_q  [pLANES];
    logic [W-1:0]                  s2Raw_q   [pLANES];
    pwl_mode_e                     s2Mode_q;
    logic                          s2Valid_q;

    logic [W-1:0]                  sFold     [pLANES];
    logic [W-1:0]                  s3Res     [pLANES];
    logic [pLANES*W-1:0]           dataOut_d;
    logic [pLANES*W-1:0]           dataOut_q;
    logic                          s3Valid_q;

    // Magnitude with the most negative word pinned to the largest positive one.
    function automatic logic [W-1:0] satAbs(input logic [W-1:0] v);
        if (!v[W-1]) begin
            return v;
        end else if (v == minNeg) begin
            return maxPos;
        end else begin
            return -v;
        end
    endfunction

`ifdef PWL_ACT_TANH_EN
    // 2x with clamping to the signed range, used to turn sigmoid into tanh.
    function automatic logic [W-1:0] satDouble(input logic [W-1:0] v);
        if (v[W-1] != v[W-2]) begin
            return v[W-1] ? minNeg : maxPos;
        end else begin
            return {v[W-2:0], 1'b0};
        end
    endfunction
`endif

    assign inMode    = pwl_mode_e'(in_mode);
    assign advance   = !s3Valid_q || out_ready;
    assign in_ready  = advance && rst_n;
    assign out_valid = s3Valid_q;
    assign data_out  = dataOut_q;

    // Stage 1 front end: unpack lanes, optionally double for tanh, take magnitude and sign.
    always_comb begin
        for (int i = 0; i < pLANES; i++) begin
            laneIn[i]    = data_in[i*W +: W];
            s1Operand[i] = laneIn[i];
`ifdef PWL_ACT_TANH_EN
            if (inMode == PWL_TANH) begin
                s1Operand[i] = satDouble(laneIn[i]);
            end
`endif
            s1Lane_d[i].value = PWL_MAX_W'(satAbs(s1Operand[i]));
            s1Lane_d[i].sign  = s1Operand[i][W-1];
        end
    end

    for (genvar g = 0; g < pLANES; g++) begin : g_seg
        pwl_sigmoid_seg #(
            .pDATA_WIDTH (pDATA_WIDTH),
            .pFRAC_NUM   (pFRAC_NUM)
        ) u_seg (
            .a_i (s1Lane_q[g].value[W-1:0]),
            .p_o (segP[g])
        );
    end

    // Stage 2 payload: segment result with the sign carried alongside.
    always_comb begin
        for (int i = 0; i < pLANES; i++) begin
            s2Lane_d[i].value = PWL_MAX_W'(segP[i]);
            s2Lane_d[i].sign  = s1Lane_q[i].sign;
        end
    end

    // Stage 3 front end: fold the sign back, apply tanh post-scale, and pick by mode.
    always_comb begin
        dataOut_d = '0;
        for (int i = 0; i < pLANES; i++) begin
            sFold[i] = s2Lane_q[i].sign ? (cOne - s2Lane_q[i].value[W-1:0])
                                        : s2Lane_q[i].value[W-1:0];
            case (s2Mode_q)
                PWL_SIGMOID: s3Res[i] = sFold[i];
`ifdef PWL_ACT_TANH_EN
                PWL_TANH:    s3Res[i] = {sFold[i][W-2:0], 1'b0} - cOne;
`endif
                PWL_RELU:    s3Res[i] = s2Raw_q[i][W-1] ? '0 : s2Raw_q[i];
                default:     s3Res[i] = s2Raw_q[i];
            endcase
            dataOut_d[i*W +: W] = s3Res[i];
        end
    end

    // All three stages shift together on advance and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            s3Valid_q <= 1'b0;
            s1Mode_q  <= PWL_SIGMOID;
            s2Mode_q  <= PWL_SIGMOID;
            dataOut_q <= '0;
            for (int i = 0; i < pLANES; i++) begin
                s1Lane_q[i] <= '0;
                s2Lane_q[i] <= '0;
                s1Raw_q[i]  <= '0;
                s2Raw_q[i]  <= '0;
            end
        end else if (advance) begin
            s1Valid_q <= in_valid;
            s2Valid_q <= s1Valid_q;
            s3Valid_q <= s2Valid_q;
            s1Mode_q  <= inMode;
            s2Mode_q  <= s1Mode_q;
            dataOut_q <= dataOut_d;
            for (int i = 0; i < pLANES; i++) begin
                s1Lane_q[i] <= s1Lane_d[i];
                s2Lane_q[i] <= s2Lane_d[i];
                s1Raw_q[i]  <= laneIn[i];
                s2Raw_q[i]  <= s1Raw_q[i];
            end
        end
    end

endmodule

// File: tb/tb_pwl_activation.sv
// Scoreboard bench for pwl_activation: stimulus pushes expected beats computed
// by an arithmetic reference model; a negedge monitor pops and compares.
module tb_pwl_activation;

    localparam int  W    = 32;
    localparam int  F    = 16;
    localparam int  L    = 4;
    localparam longint ONE  = 64'sd1 << F;
    localparam longint MAXV = (64'sd1 << (W-1)) - 1;
    localparam longint MINV = -(64'sd1 << (W-1));

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_mode;
    logic [L*W-1:0] data_in;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] data_out;

    typedef struct {
        logic [L*W-1:0] data;
        int             cyc;
        bit             chkLat;
    } sbEntry_t;

    sbEntry_t       sbQ[$];
    int             checkCount = 0;
    int             passCount  = 0;
    int             cyc        = 0;
    int             readyMode  = 0;
    bit             prevStall  = 0;
    logic [L*W-1:0] prevData   = '0;

    pwl_activation #(
        .pDATA_WIDTH (W),
        .pFRAC_NUM   (F),
        .pLANES      (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc++;

    // Downstream ready: held high, random, or held low depending on readyMode.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        checkCount++;
        $display("[TB] FAIL %s", name);
    endtask

    // Reference: positive-half sigmoid straight from the segment table.
    function automatic longint posSig(input longint a);
        if (a >= 5 * ONE)             return ONE;
        else if (a >= (19 * ONE) / 8) return (27 * ONE) / 32 + a / 32;
        else if (a >= ONE)            return (5 * ONE) / 8 + a / 8;
        else                          return ONE / 2 + a / 4;
    endfunction

    function automatic longint sigOf(input longint x);
        longint a;
        a = (x < 0) ? -x : x;
        if (a > MAXV) a = MAXV;
        return (x < 0) ? ONE - posSig(a) : posSig(a);
    endfunction

    function automatic logic [W-1:0] modelLane(input logic [1:0] mode, input logic [W-1:0] v);
        longint x, t, r;
        x = longint'($signed(v));
        case (mode)
            2'b00: r = sigOf(x);
`ifdef PWL_ACT_TANH_EN
            2'b01: begin
                t = 2 * x;
                if (t > MAXV) t = MAXV;
                if (t < MINV) t = MINV;
                r = 2 * sigOf(t) - ONE;
            end
`endif
            2'b10: r = (x < 0) ? 0 : x;
            default: r = x;
        endcase
        return W'(r);
    endfunction

    function automatic logic [L*W-1:0] modelBeat(input logic [1:0] mode, input logic [L*W-1:0] lanes);
        logic [L*W-1:0] res;
        for (int i = 0; i < L; i++) res[i*W +: W] = modelLane(mode, lanes[i*W +: W]);
        return res;
    endfunction

    function automatic logic [W-1:0] randVal();
        int unsigned mag;
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: begin
                mag = $urandom_range(0, 6 * 65536);
                v = $urandom_range(0, 1) ? -W'(mag) : W'(mag);
            end
            2: begin
                case ($urandom_range(0, 5))
                    0: v = 32'h0001_0000;
                    1: v = 32'h0002_6000;
                    2: v = 32'h0002_5FFF;
                    3: v = 32'h0005_0000;
                    4: v = 32'hFFFD_A000;
                    default: v = 32'h0000_FFFF;
                endcase
            end
            default: v = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
        return v;
    endfunction

    function automatic logic [L*W-1:0] randBeat();
        logic [L*W-1:0] b;
        for (int i = 0; i < L; i++) b[i*W +: W] = randVal();
        return b;
    endfunction

    // Present one beat and wait (bounded) for its handshake; in_valid stays high afterwards.
    task automatic applyStimulus(input logic [1:0] mode, input logic [L*W-1:0] lanes,
                                 input bit chkLat, input bit push);
        bit accepted = 0;
        int waitCnt = 0;
        sbEntry_t e;
        in_valid = 1'b1;
        in_mode  = mode;
        data_in  = lanes;
        while (!accepted && waitCnt < 100) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                if (push) begin
                    e.data   = modelBeat(mode, lanes);
                    e.cyc    = cyc;
                    e.chkLat = chkLat;
                    sbQ.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (!accepted) failNow("accept timeout");
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        in_valid = 1'b0;
        while (sbQ.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sbQ.size() != 0) failNow({"drain timeout ", tag});
    endtask

    // Monitor: stability under stall, then pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevStall = 0;
        end else begin
            if (prevStall) checkOutput("stable while stalled", {out_valid, data_out}, {1'b1, prevData});
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    failNow("unexpected output beat");
                end else begin
                    sbEntry_t e;
                    e = sbQ.pop_front();
                    for (int i = 0; i < L; i++)
                        checkOutput($sformatf("lane%0d data", i), data_out[i*W +: W], e.data[i*W +: W]);
                    if (e.chkLat) checkOutput("latency", cyc - e.cyc, 3);
                end
            end
            prevStall = out_valid && !out_ready;
            prevData  = data_out;
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_mode  = 2'b00;
        data_in  = '0;
        #2;
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset data_out", data_out, '0);
        checkOutput("reset in_ready", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(2'b00, {32'h0006_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000}, 1, 1);
        applyStimulus(2'b00, {32'h0005_0000, 32'h8000_0000, 32'h0002_5FFF, 32'h0002_6000}, 1, 1);
        applyStimulus(2'b01, {32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_8000, 32'h0000_8000}, 1, 1);
        applyStimulus(2'b10, {32'h8000_0000, 32'h0000_0000, 32'h0001_2345, 32'hFFFF_FFFF}, 1, 1);
        applyStimulus(2'b11, {32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_2345, 32'hFFFF_FFFF}, 1, 1);
        for (int k = 0; k < 40; k++) applyStimulus(2'($urandom_range(0, 3)), randBeat(), 1, 1);
        waitDrain("directed");

        readyMode = 1;
        for (int k = 0; k < 10; k++) applyStimulus(2'b00, randBeat(), 0, 1);
        for (int k = 0; k < 30; k++) applyStimulus(2'($urandom_range(0, 3)), randBeat(), 0, 1);
        waitDrain("backpressure");

        readyMode = 2;
        applyStimulus(2'b11, {4{32'h0BAD_0001}}, 0, 0);
        applyStimulus(2'b11, {4{32'h0BAD_0002}}, 0, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in-flight beat at output", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("out_valid drops on reset", out_valid, 1'b0);
        checkOutput("in_ready low in reset", in_ready, 1'b0);
        readyMode = 0;
        @(posedge clk);
        #1;
        checkOutput("data_out cleared by reset", data_out, '0);
        rst_n = 1'b1;
        applyStimulus(2'b00, {32'h0000_4000, 32'hFFFE_0000, 32'h0003_0000, 32'h0000_0000}, 1, 1);
        waitDrain("after reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
